// File: rtl/pipelined_adder_pkg.sv
// Shared helpers for pipelined_adder: chunk-width computation and parameter legality.
package pipelined_adder_pkg;

  localparam int DEFAULT_WIDTH  = 16;
  localparam int DEFAULT_STAGES = 4;

  function automatic int chunk_width(input int width, input int stages);
    return (stages > 0) ? (width / stages) : width;
  endfunction

  // WIDTH must split into STAGES equal, non-empty chunks.
  function automatic bit params_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/pipelined_adder_chunk.sv
// Combinational CHUNK-bit ripple-carry adder; one instance per pipeline stage.
module adder_chunk
  import pipelined_adder_pkg::*;
#(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  logic carry;

  always_comb begin
    carry = cin;
    sum   = '0;
    for (int i = 0; i < CHUNK; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined adder with STAGES chunked carry stages and valid/ready handshaking.
// Optional signed-overflow output enabled by defining PIPELINED_ADDER_OVF_EN.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PIPELINED_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CHUNK = chunk_width(WIDTH, STAGES);

  if (!params_ok(WIDTH, STAGES)) begin : g_bad_params
    $error("pipelined_adder: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
  end

  // Handshake: a beat transfers on any rising edge where valid && ready.
  // The whole pipe moves as one shift register: adv=1 shifts every stage
  // (bubbles included), adv=0 freezes every register. in_ready is adv itself.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Stage k holds the not-yet-added operand bits [WIDTH-1 : k*CHUNK] (skew)
  // and the sum bits already produced [k*CHUNK-1 : 0] (deskew).
  for (genvar k = 0; k < STAGES; k++) begin : stg
    localparam int REM = WIDTH - k * CHUNK;

    logic                   vld;
    logic [REM-1:0]         rem_a;
    logic [REM-1:0]         rem_b;
    logic                   carry;
    logic [CHUNK-1:0]       csum;
    logic                   cco;
    logic [(k+1)*CHUNK-1:0] res;

    adder_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a    (rem_a[CHUNK-1:0]),
      .b    (rem_b[CHUNK-1:0]),
      .cin  (carry),
      .sum  (csum),
      .cout (cco)
    );

    if (k == 0) begin : g_load
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld <= 1'b0;
        end else if (adv) begin
          vld <= in_valid;
        end
      end

      always_ff @(posedge clk) begin
        if (adv && in_valid) begin
          rem_a <= a;
          rem_b <= b;
          carry <= cin;
        end
      end

      assign res = csum;
    end else begin : g_load
      logic [k*CHUNK-1:0] done_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld <= 1'b0;
        end else if (adv) begin
          vld <= stg[k-1].vld;
        end
      end

      always_ff @(posedge clk) begin
        if (adv && stg[k-1].vld) begin
          rem_a  <= stg[k-1].rem_a[REM+CHUNK-1:CHUNK];
          rem_b  <= stg[k-1].rem_b[REM+CHUNK-1:CHUNK];
          carry  <= stg[k-1].cco;
          done_q <= stg[k-1].res;
        end
      end

      assign res = {csum, done_q};
    end
  end

  logic             last_vld;
  logic [WIDTH-1:0] last_res;
  logic             last_cout;
  assign last_vld  = stg[STAGES-1].vld;
  assign last_res  = stg[STAGES-1].res;
  assign last_cout = stg[STAGES-1].cco;

`ifdef PIPELINED_ADDER_OVF_EN
  // Sign bits of a and b ride along in the skewed operand chunk of the last stage.
  logic last_ovf;
  assign last_ovf = (stg[STAGES-1].rem_a[CHUNK-1] == stg[STAGES-1].rem_b[CHUNK-1]) &&
                    (stg[STAGES-1].csum[CHUNK-1] != stg[STAGES-1].rem_a[CHUNK-1]);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
`ifdef PIPELINED_ADDER_OVF_EN
      ovf       <= 1'b0;
`endif
    end else if (adv) begin
      out_valid <= last_vld;
      if (last_vld) begin
        sum  <= last_res;
        cout <= last_cout;
`ifdef PIPELINED_ADDER_OVF_EN
        ovf  <= last_ovf;
`endif
      end
    end
  end

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (WIDTH=16, STAGES=4); honours PIPELINED_ADDER_OVF_EN.
module tb_pipelined_adder;

  localparam int WIDTH  = 16;
  localparam int STAGES = 4;
`ifdef PIPELINED_ADDER_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

`ifndef PIPELINED_ADDER_OVF_EN
  assign ovf = 1'b0;
`endif

  pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef PIPELINED_ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard state ----------------
  logic [17:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_retry  = 0;
  int run_len  = 0;
  int max_run  = 0;

  // Directed vectors: {cout,sum} and signed overflow worked out by hand.
  logic [15:0] tab_a   [6] = '{16'h1234, 16'h8000, 16'h00FF, 16'hFFFF, 16'h7FFF, 16'h8000};
  logic [15:0] tab_b   [6] = '{16'h4321, 16'h8000, 16'h0F01, 16'hFFFF, 16'h0001, 16'hFFFF};
  logic        tab_c   [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [16:0] tab_cs  [6] = '{17'h05555, 17'h10000, 17'h01000, 17'h1FFFF, 17'h08000, 17'h17FFF};
  logic        tab_ovf [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [17:0] hexp(input logic o, input logic [16:0] cs);
    return {OVF_ON ? o : 1'b0, cs};
  endfunction

  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y, input logic c);
    logic [16:0] s;
    logic        o;
    s = {1'b0, x} + {1'b0, y} + {16'h0, c};
    o = (x[15] == y[15]) && (s[15] != x[15]);
    return hexp(o, s);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic [15:0] x, input logic [15:0] y, input logic c,
                           input logic rdy, input logic [17:0] e);
    int  tries;
    bit  done;
    tries = 0;
    done  = 1'b0;
    @(negedge clk);
    in_valid  = 1'b1;
    a         = x;
    b         = y;
    cin       = c;
    out_ready = rdy;
    while (!done) begin
      #1;
      if (in_ready) begin
        exp_q.push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
      if (!done) begin
        tries++;
        n_retry++;
        if (tries > 100) begin
          check("send_timeout", 32'(tries), 32'd0);
          done = 1'b1;
        end else begin
          @(negedge clk);
        end
      end
    end
  endtask

  task automatic idle(input int n, input logic rdy);
    repeat (n) begin
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = rdy;
    end
  endtask

  // Checks out_valid on the negedges after accept edges N..N+4.
  task automatic latency_check(input string tag);
    for (int i = 0; i <= STAGES; i++) begin
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #1;
      check(tag, 32'(out_valid), 32'(i == STAGES));
    end
  endtask

  // ---------------- output monitor ----------------
  initial begin
    logic [17:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (out_valid) run_len++;
      else run_len = 0;
      if (run_len > max_run) max_run = run_len;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 32'({ovf, cout, sum}), 32'h3FFFF);
        end else begin
          e = exp_q.pop_front();
          check("out_beat", 32'({ovf, cout, sum}), 32'(e));
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    check("watchdog_timeout", 32'd1, 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // carry ripples across every chunk
    send_beat(16'hFFFF, 16'h0001, 1'b0, 1'b1, hexp(1'b0, 17'h10000));
    latency_check("lat_carry_all");
    idle(2, 1'b1);

    // directed table, back to back
    for (int i = 0; i < 6; i++)
      send_beat(tab_a[i], tab_b[i], tab_c[i], 1'b1, hexp(tab_ovf[i], tab_cs[i]));
    idle(6, 1'b1);

    // streaming 20 random beats
    max_run = 0;
    n_retry = 0;
    for (int i = 0; i < 20; i++) begin
      logic [15:0] x;
      logic [15:0] y;
      logic        c;
      x = 16'($urandom_range(0, 65535));
      y = 16'($urandom_range(0, 65535));
      c = 1'($urandom_range(0, 1));
      send_beat(x, y, c, 1'b1, model(x, y, c));
    end
    idle(6, 1'b1);
    check("stream_run", 32'(max_run), 32'd20);
    check("stream_retry", 32'(n_retry), 32'd0);

    // backpressure: hold a result for 5 cycles
    send_beat(16'h0F0F, 16'h0101, 1'b0, 1'b0, hexp(1'b0, 17'h01010));
    send_beat(16'hA5A5, 16'h5A5A, 1'b0, 1'b0, hexp(1'b0, 17'h0FFFF));
    idle(3, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      #1;
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_sum", 32'(sum), 32'h1010);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    idle(6, 1'b1);
    check("bp_queue_empty", 32'(exp_q.size()), 32'd0);

    // reset with beats in flight
    send_beat(16'h1111, 16'h2222, 1'b0, 1'b1, hexp(1'b0, 17'h03333));
    send_beat(16'h4444, 16'h1111, 1'b1, 1'b1, hexp(1'b0, 17'h05556));
    send_beat(16'h0101, 16'h1010, 1'b0, 1'b1, hexp(1'b0, 17'h01111));
    idle(2, 1'b1);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_sum", 32'(sum), 32'd0);
    check("mid_rst_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(8, 1'b1);

    // carry-in only, cold start after reset
    send_beat(16'h0000, 16'h0000, 1'b1, 1'b1, hexp(1'b0, 17'h00001));
    latency_check("lat_cin_only");
    idle(4, 1'b1);

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined successor to the 4-bit ripple-carry adder. Adds two WIDTH-bit operands plus carry-in. The carry chain is split into STAGES equal chunks with a register between chunks, so the critical path is one CHUNK-bit ripple regardless of WIDTH. A valid/ready handshake with full backpressure on both sides lets it sit between streaming datapath blocks at one result per cycle.

## Interface
- WIDTH, 16, operand/sum width; must be a multiple of STAGES
- STAGES, 4, pipeline depth and chunk count; 1 ≤ STAGES ≤ WIDTH
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand beat present
- in_ready  out  1  adder can accept a beat this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in
- out_valid  out  1  result beat present
- out_ready  in  1  downstream accepts result
- sum  out  WIDTH  (a + b + cin) mod 2^WIDTH
- cout  out  1  carry out of bit WIDTH-1
- ovf  out  1  signed overflow; present only with PIPELINED_ADDER_OVF_EN

## Operation
- Chunk width: CHUNK = WIDTH/STAGES. Stage k adds bits [k·CHUNK +: CHUNK] of a and b, plus the carry registered by stage k-1. Stage 0 uses cin.
- Skew registers: operand chunks for stage k are delayed k cycles.
- Deskew registers: result chunk from stage k is delayed STAGES-1-k cycles, so all chunks of one sum emerge together.
- Each stage holds a valid bit. Stage 0 loads on an input handshake (in_valid && in_ready).
- Global advance: adv = !out_valid || out_ready. When adv=1, every stage shifts forward by one, bubbles included. When adv=0, every register holds.
- in_ready = adv. It is combinational from out_ready and is not registered.
- Arithmetic is unsigned modulo 2^WIDTH. cout is the carry out of the final stage.
- Operands are sampled only on the handshake. a, b and cin are don't-care otherwise.
- Reset values: all valid bits 0, out_valid=0, sum=0, cout=0, ovf=0. Contents of the skew and deskew registers are don't-care once their valid bit is 0.
- Reset mid-operation: all in-flight beats are discarded, with no partial output. The first accept after rst deasserts behaves as from cold.
- out_valid && !out_ready: sum, cout and ovf hold stable until the beat is accepted.
- Simultaneous output accept and input accept in the same cycle is legal, giving full throughput.

## Timing
- Latency: a beat accepted at rising edge N appears with out_valid=1 after edge N+STAGES, provided adv=1 on every intervening edge.
- Each stall cycle (adv=0) adds exactly one cycle of latency to every in-flight beat.
- Throughput: 1 beat/cycle while out_ready=1.
- Combinational paths: out_ready→in_ready only. There is no path from a or b to any output.
- Critical path: one CHUNK-bit ripple plus a carry register.

## Configuration
- PIPELINED_ADDER_OVF_EN defined:
  - port ovf exists.
  - ovf = (a[W-1]==b[W-1]) && (sum[W-1]!=a[W-1]). It is computed in the final stage from the skewed sign bits and is aligned with sum.
- Not defined: the port is absent and no sign-bit skew registers are built.

## Structure
- Package pipelined_adder_pkg holds the function that computes CHUNK and the elaboration-time checks (WIDTH % STAGES == 0, STAGES ≥ 1).
- Sub-module adder_chunk: a combinational CHUNK-bit ripple-carry adder, instantiated once per stage by a generate loop.
- The top level owns the skew, deskew, valid and carry registers and the handshake logic.

## Test plan
All scenarios use WIDTH=16, STAGES=4.
1. Carry across all chunks: a=0xFFFF, b=0x0001, cin=0, out_ready=1 → sum=0x0000, cout=1, out_valid 4 cycles after accept.
2. Streaming: 20 back-to-back random beats with out_ready=1 → 20 consecutive out_valid cycles; results match a reference model in order.
3. Backpressure: hold out_ready=0 for 5 cycles while a result is present → sum stable, in_ready=0, no beat lost or duplicated after release.
4. Reset mid-flight: accept 3 beats, assert rst for 1 cycle → out_valid=0 and sum=0 immediately; no stale beat appears afterwards.
5. Carry-in only: a=0x0000, b=0x0000, cin=1 → sum=0x0001, cout=0.
6. With PIPELINED_ADDER_OVF_EN:
   - a=0x7FFF, b=0x0001 → ovf=1, sum=0x8000.
   - a=0x8000, b=0xFFFF → ovf=1, sum=0x7FFF, cout=1.
